ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative RV32M multiply/divide unit that sits in the EX stage beside the ALU and executes the eight M-extension operations over multiple cycles. It holds the pipeline through a stall request until the result is ready. Width and radix (bits retired per cycle) are parametrised. It aborts cleanly on a pipeline flush.

## Interface
- DATA_WIDTH, 32, operand/result width; must be even
- BITS_PER_CYCLE, 1, bits retired per iteration; one of 1, 2, 4; must divide DATA_WIDTH
- REGISTER_ADDR_WIDTH, 5, destination tag width
- Clock: one clock `clk`. Reset: `rst_n`, asynchronous, active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid_EX  in  1  M-op present in EX; held high by the pipeline while stalled
- funct3_EX  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_val_EX  in  DATA_WIDTH  forwarded rs1 operand
- rs2_val_EX  in  DATA_WIDTH  forwarded rs2 operand
- rd_EX  in  REGISTER_ADDR_WIDTH  destination register
- flush_EX  in  1  kill the in-flight op
- stall_EX  out  1  hold IF/ID/EX; combinational
- done_EX  out  1  result valid this cycle
- muldiv_res_EX  out  DATA_WIDTH  result
- rd_res_EX  out  REGISTER_ADDR_WIDTH  latched destination tag

## Operation
- N = DATA_WIDTH/BITS_PER_CYCLE iterations.
- States:
  - IDLE: on in_valid_EX && !flush_EX, latch the op, operand magnitudes, result sign, and rd. Go to DONE if special, else CALC with count=N.
  - CALC: one BITS_PER_CYCLE step per cycle, count decrements. Go to FIX when count reaches 1.
  - FIX: apply sign correction and select the high/low half or quotient/remainder into the result register. Go to DONE.
  - DONE: done_EX=1 for exactly one cycle, then IDLE. A held in_valid_EX is never re-accepted in DONE.
- Stall rule: stall_EX = in_valid_EX && state!=DONE && !flush_EX. The pipeline advances at the end of the DONE cycle. The next M-op can be accepted in the following IDLE cycle.
- Multiply:
  - Shift-add on magnitudes into a 2*DATA_WIDTH product.
  - Operand signedness: MUL and MULH signed×signed; MULHSU signed rs1 × unsigned rs2; MULHU unsigned×unsigned.
  - MUL returns the low half; the other three return the high half.
  - Negation is applied to the full 2*DATA_WIDTH product in FIX.
- Divide:
  - Restoring division on magnitudes, BITS_PER_CYCLE quotient bits per cycle.
  - Quotient sign is the XOR of the operand signs (signed ops only). Remainder takes the sign of the dividend.
- Special cases take the IDLE→DONE path; the result is computed at latch:
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return rs1.
  - Signed overflow (rs1 = most-negative, rs2 = −1): DIV returns rs1; REM returns 0.
- Flush:
  - flush_EX in any state → IDLE on the next edge; done_EX is not raised.
  - flush_EX together with in_valid_EX in IDLE: flush wins, nothing is latched.
- Reset: state=IDLE; done_EX=0; muldiv_res_EX=0; rd_res_EX=0; all internal registers 0. Reset asserted mid-operation drops the op.

## Timing
- Op accepted on edge E0 in IDLE. Normal path: CALC for N cycles, FIX one cycle. done_EX is high in cycle N+2 after E0, so total EX occupancy is N+3 cycles including the IDLE accept cycle.
- DATA_WIDTH=32, BITS_PER_CYCLE=1: done_EX is high 34 cycles after accept. With BITS_PER_CYCLE=4, that becomes 10 cycles.
- Special path: done_EX is high in the cycle after accept.
- muldiv_res_EX and rd_res_EX are registered. They are stable from DONE until the next accept.
- Outputs depend only on registered state, except stall_EX.

## Structure
- Package `ex_muldiv_pkg` holds:
  - funct3 op encodings
  - state enum (IDLE, CALC, FIX, DONE)
  - helper functions: is_div(op), is_signed_rs1(op), is_signed_rs2(op)
- Sub-module `muldiv_iter_step`: combinational, one BITS_PER_CYCLE step. It performs both the shift-add and the restoring-subtract chain, selected by a mode input. The top holds only the FSM and registers.

## Test plan
- MUL 7×(−3), DATA_WIDTH=32, BITS_PER_CYCLE=1 → done_EX at accept+34, result 0xFFFFFFEB; stall_EX high from the accept cycle through the FIX cycle, low in DONE.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU of the same operands → 0xFFFFFFFE.
- DIV −7/2 → −3 (0xFFFFFFFD); REM −7/2 → −1; DIVU 100/7 → 14; REMU 100/7 → 2; repeat with BITS_PER_CYCLE=4 → done at accept+10.
- DIV x/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM of the same operands → 0. All four finish with done in the cycle after accept.
- Flush at CALC cycle 5 → IDLE next cycle, no done_EX. A new DIVU 9/3 issued immediately → result 3 with rd_res_EX equal to the new rd.
- rst_n low mid-CALC → all outputs 0 asynchronously. Also check that in_valid_EX held high through DONE produces exactly one done_EX pulse.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - RV32M op encodings, FSM states and operand-class helpers
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_rs1(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_rs2(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - EX-stage request/response bundle between pipeline and mul/div unit
interface ex_muldiv_if #(
  parameter int DATA_WIDTH          = 32,
  parameter int REGISTER_ADDR_WIDTH = 5
);
  logic                           in_valid_EX;
  logic [2:0]                     funct3_EX;
  logic [DATA_WIDTH-1:0]          rs1_val_EX;
  logic [DATA_WIDTH-1:0]          rs2_val_EX;
  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX;
  logic                           flush_EX;
  logic                           stall_EX;
  logic                           done_EX;
  logic [DATA_WIDTH-1:0]          muldiv_res_EX;
  logic [REGISTER_ADDR_WIDTH-1:0] rd_res_EX;

  modport master (
    output in_valid_EX, funct3_EX, rs1_val_EX, rs2_val_EX, rd_EX, flush_EX,
    input  stall_EX, done_EX, muldiv_res_EX, rd_res_EX
  );

  modport slave (
    input  in_valid_EX, funct3_EX, rs1_val_EX, rs2_val_EX, rd_EX, flush_EX,
    output stall_EX, done_EX, muldiv_res_EX, rd_res_EX
  );
endinterface

// File: rtl/muldiv_iter_step.sv
// rtl/muldiv_iter_step.sv - one iteration of shift-add multiply or restoring divide
module muldiv_iter_step #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  div_mode,
  input  logic [DATA_WIDTH-1:0] hi_in,
  input  logic [DATA_WIDTH-1:0] lo_in,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic [DATA_WIDTH:0]   wide;
  logic [DATA_WIDTH:0]   diff;
  logic                  ge;

  // hi is the product high half / partial remainder; lo is multiplier / dividend-becoming-quotient
  always_comb begin
    hi   = hi_in;
    lo   = lo_in;
    wide = '0;
    diff = '0;
    ge   = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (div_mode) begin
        wide = {hi, lo[DATA_WIDTH-1]};
        diff = wide - {1'b0, operand};
        ge   = (wide >= {1'b0, operand});
        lo   = {lo[DATA_WIDTH-2:0], ge};
        hi   = ge ? diff[DATA_WIDTH-1:0] : wide[DATA_WIDTH-1:0];
      end else begin
        wide = {1'b0, hi} + ({1'b0, operand} & {(DATA_WIDTH+1){lo[0]}});
        lo   = {wide[0], lo[DATA_WIDTH-1:1]};
        hi   = wide[DATA_WIDTH:1];
      end
    end
    hi_out = hi;
    lo_out = lo;
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit with pipeline stall and flush
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int BITS_PER_CYCLE      = 1,
  parameter int REGISTER_ADDR_WIDTH = 5
) (
  input logic        clk,
  input logic        rst_n,
  ex_muldiv_if.slave bus
);
  localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);

  muldiv_state_e                  state_q, state_d;
  muldiv_op_e                     op_q;
  logic [DATA_WIDTH-1:0]          hi_q, lo_q, opnd_q, res_q;
  logic [CNT_W-1:0]               cnt_q;
  logic                           neg_q;
  logic [REGISTER_ADDR_WIDTH-1:0] rd_q;

  muldiv_op_e              op_in;
  logic                    sgn1, sgn2, div_zero, ovf, special, accept;
  logic [DATA_WIDTH-1:0]   mag1, mag2, special_res, step_hi, step_lo;
  logic [DATA_WIDTH-1:0]   div_q, div_r, fix_res;
  logic [2*DATA_WIDTH-1:0] prod_s;

  assign op_in    = muldiv_op_e'(bus.funct3_EX);
  assign sgn1     = is_signed_rs1(op_in) & bus.rs1_val_EX[DATA_WIDTH-1];
  assign sgn2     = is_signed_rs2(op_in) & bus.rs2_val_EX[DATA_WIDTH-1];
  assign mag1     = sgn1 ? -bus.rs1_val_EX : bus.rs1_val_EX;
  assign mag2     = sgn2 ? -bus.rs2_val_EX : bus.rs2_val_EX;
  assign div_zero = is_div(op_in) && (bus.rs2_val_EX == '0);
  assign ovf      = (op_in == OP_DIV || op_in == OP_REM) && (bus.rs2_val_EX == '1) &&
                    (bus.rs1_val_EX == {1'b1, {(DATA_WIDTH-1){1'b0}}});
  assign special  = div_zero | ovf;
  assign accept   = (state_q == S_IDLE) && bus.in_valid_EX && !bus.flush_EX;

  // Divide-by-zero wins over overflow; the two cannot coincide anyway since rs2 differs
  assign special_res = div_zero ? (is_rem(op_in) ? bus.rs1_val_EX : '1)
                                : (is_rem(op_in) ? '0 : bus.rs1_val_EX);

  muldiv_iter_step #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .div_mode (is_div(op_q)),
    .hi_in    (hi_q),
    .lo_in    (lo_q),
    .operand  (opnd_q),
    .hi_out   (step_hi),
    .lo_out   (step_lo)
  );

  assign prod_s  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign div_q   = neg_q ? -lo_q : lo_q;
  assign div_r   = neg_q ? -hi_q : hi_q;
  assign fix_res = is_div(op_q) ? (is_rem(op_q) ? div_r : div_q)
                 : (op_q == OP_MUL) ? prod_s[DATA_WIDTH-1:0] : prod_s[2*DATA_WIDTH-1:DATA_WIDTH];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush_EX) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op_in;
        neg_q  <= is_rem(op_in) ? sgn1 : (sgn1 ^ sgn2);
        rd_q   <= bus.rd_EX;
        hi_q   <= '0;
        lo_q   <= is_div(op_in) ? mag1 : mag2;
        opnd_q <= is_div(op_in) ? mag2 : mag1;
        cnt_q  <= CNT_W'(N);
        if (special) res_q <= special_res;
      end else if (state_q == S_CALC && !bus.flush_EX) begin
        hi_q  <= step_hi;
        lo_q  <= step_lo;
        cnt_q <= cnt_q - CNT_W'(1);
      end else if (state_q == S_FIX && !bus.flush_EX) begin
        res_q <= fix_res;
      end
    end
  end

  assign bus.stall_EX      = bus.in_valid_EX && (state_q != S_DONE) && !bus.flush_EX;
  assign bus.done_EX       = (state_q == S_DONE);
  assign bus.muldiv_res_EX = res_q;
  assign bus.rd_res_EX     = rd_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed-vector bench for ex_muldiv_unit at radix 1 and radix 4
module tb_ex_muldiv_unit;
  import ex_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_if #(.DATA_WIDTH(32), .REGISTER_ADDR_WIDTH(5)) b1 ();
  ex_muldiv_if #(.DATA_WIDTH(32), .REGISTER_ADDR_WIDTH(5)) b4 ();

  ex_muldiv_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1), .REGISTER_ADDR_WIDTH(5)) u_r1 (
    .clk (clk), .rst_n (rst_n), .bus (b1)
  );
  ex_muldiv_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4), .REGISTER_ADDR_WIDTH(5)) u_r4 (
    .clk (clk), .rst_n (rst_n), .bus (b4)
  );

  logic        sel = 1'b0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd = '0;

  assign b1.in_valid_EX = valid & ~sel;
  assign b4.in_valid_EX = valid & sel;
  assign b1.flush_EX    = flush & ~sel;
  assign b4.flush_EX    = flush & sel;
  assign b1.funct3_EX   = f3;
  assign b4.funct3_EX   = f3;
  assign b1.rs1_val_EX  = a;
  assign b4.rs1_val_EX  = a;
  assign b1.rs2_val_EX  = b;
  assign b4.rs2_val_EX  = b;
  assign b1.rd_EX       = rd;
  assign b4.rd_EX       = rd;

  wire        stall  = sel ? b4.stall_EX      : b1.stall_EX;
  wire        done   = sel ? b4.done_EX       : b1.done_EX;
  wire [31:0] res    = sel ? b4.muldiv_res_EX : b1.muldiv_res_EX;
  wire [4:0]  rd_res = sel ? b4.rd_res_EX     : b1.rd_res_EX;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one op just after a rising edge, holds in_valid through DONE, then releases it
  task automatic run_op(input logic s, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] d, input logic [31:0] exp,
                        input int lat_exp, input string tag);
    int   lat = 0;
    logic stall_bad = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sel = s; f3 = op; a = x; b = y; rd = d; valid = 1'b1;
    @(negedge clk);
    check_eq({tag, "_acc_stall"}, stall, 1);
    check_eq({tag, "_acc_done"}, done, 0);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (!stall) stall_bad = 1'b1;
    end
    check_eq({tag, "_latency"}, lat, lat_exp);
    check_eq({tag, "_busy_stall"}, stall_bad, 0);
    check_eq({tag, "_res"}, res, exp);
    check_eq({tag, "_rd"}, rd_res, d);
    check_eq({tag, "_done_stall"}, stall, 0);
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_one_pulse"}, done, 0);
  endtask

  initial begin
    logic seen_done;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_r1", {b1.stall_EX, b1.done_EX, b1.rd_res_EX, b1.muldiv_res_EX}, 0);
    check_eq("rst_r4", {b4.stall_EX, b4.done_EX, b4.rd_res_EX, b4.muldiv_res_EX}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(1'b0, OP_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34, "mul_r1");
    run_op(1'b0, OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 34, "mulh_r1");
    run_op(1'b0, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 34, "mulhsu_r1");
    run_op(1'b0, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, 34, "mulhu_r1");
    run_op(1'b0, OP_DIV,    32'hFFFF_FFF9, 32'd2,   5'd9,  32'hFFFF_FFFD, 34, "div_r1");
    run_op(1'b0, OP_REM,    32'hFFFF_FFF9, 32'd2,   5'd10, 32'hFFFF_FFFF, 34, "rem_r1");
    run_op(1'b0, OP_DIVU,   32'd100,      32'd7,    5'd11, 32'd14,        34, "divu_r1");
    run_op(1'b0, OP_REMU,   32'd100,      32'd7,    5'd12, 32'd2,         34, "remu_r1");

    run_op(1'b1, OP_DIV,    32'hFFFF_FFF9, 32'd2,   5'd13, 32'hFFFF_FFFD, 10, "div_r4");
    run_op(1'b1, OP_REM,    32'hFFFF_FFF9, 32'd2,   5'd14, 32'hFFFF_FFFF, 10, "rem_r4");
    run_op(1'b1, OP_DIVU,   32'd100,      32'd7,    5'd15, 32'd14,        10, "divu_r4");
    run_op(1'b1, OP_REMU,   32'd100,      32'd7,    5'd16, 32'd2,         10, "remu_r4");
    run_op(1'b1, OP_MUL,    32'd7,        32'hFFFF_FFFD, 5'd17, 32'hFFFF_FFEB, 10, "mul_r4");

    run_op(1'b0, OP_DIV,    32'd42,        32'd0,         5'd18, 32'hFFFF_FFFF, 1, "div0");
    run_op(1'b0, OP_REMU,   32'd5,         32'd0,         5'd19, 32'd5,         1, "remu0");
    run_op(1'b0, OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1, "div_ovf");
    run_op(1'b0, OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'd0,         1, "rem_ovf");

    // flush in the fifth CALC cycle, then a new op right behind it
    @(posedge clk);
    #1 sel = 1'b0; f3 = OP_DIVU; a = 32'd1000; b = 32'd7; rd = 5'd22; valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check_eq("flush_stall", stall, 0);
    run_op(1'b0, OP_DIVU, 32'd9, 32'd3, 5'd23, 32'd3, 34, "after_flush");

    // flush together with a request in IDLE: nothing is latched
    @(posedge clk);
    #1 sel = 1'b0; f3 = OP_DIV; a = 32'd5; b = 32'd0; rd = 5'd24; valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check_eq("idle_flush_stall", stall, 0);
    @(posedge clk);
    #1 valid = 1'b0; flush = 1'b0;
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check_eq("idle_flush_no_done", seen_done, 0);
    check_eq("idle_flush_rd", rd_res, 5'd23);

    // asynchronous reset in the middle of CALC
    @(posedge clk);
    #1 sel = 1'b0; f3 = OP_MUL; a = 32'd3; b = 32'd5; rd = 5'd25; valid = 1'b1;
    repeat (10) @(posedge clk);
    #2 valid = 1'b0; rst_n = 1'b0;
    #1;
    check_eq("mid_rst_r1", {b1.stall_EX, b1.done_EX, b1.rd_res_EX, b1.muldiv_res_EX}, 0);
    check_eq("mid_rst_r4", {b4.stall_EX, b4.done_EX, b4.rd_res_EX, b4.muldiv_res_EX}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
